vga_fb: RTL and testbench

VGA_FB -- requirements
Module: vga_fb

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_timing.sv | 43 ++++
 rtl/vga_fb.sv | 105 ++++++++++
 tb/tb_vga_fb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing constants and framebuffer helpers
//
// Shared by vga_timing and vga_fb.
//   - Horizontal and vertical timing constants (visible, porches, sync, total).
//   - Framebuffer geometry: 320x240 bytes, each pixel doubled in both axes.
//   - fb_index(): byte address of the framebuffer pixel behind screen pixel (x,y).
//   - vga_ctrl_t: control bits carried down the video pipeline.
package vga_pkg;

   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = 800;

   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = 525;

   localparam int FB_W    = 320;
   localparam int FB_H    = 240;
   localparam int FB_AW   = 17;

   // Inclusive sync windows, derived from the porch widths above.
   localparam int H_SYNC_FIRST = H_VIS + H_FP;
   localparam int H_SYNC_LAST  = H_VIS + H_FP + H_SYNC - 1;
   localparam int V_SYNC_FIRST = V_VIS + V_FP;
   localparam int V_SYNC_LAST  = V_VIS + V_FP + V_SYNC - 1;

   // Control bits that travel alongside the pixel through the pipeline.
   typedef struct packed {
      logic vis;
      logic hs;
      logic vs;
   } vga_ctrl_t;

   // (y/2)*FB_W + x/2; the halving gives the 2x2 pixel doubling.
   function automatic logic [FB_AW-1:0] fb_index(input logic [9:0] x, input logic [9:0] y);
      logic [FB_AW-1:0] xe;
      logic [FB_AW-1:0] ye;
      xe = FB_AW'(x);
      ye = FB_AW'(y);
      return ((ye >> 1) * FB_AW'(FB_W)) + (xe >> 1);
   endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA pixel/line counters and stage-0 sync/visible decode
//
// Ports:
//   clock_25  in   pixel clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   x         out  horizontal counter 0..H_TOTAL-1
//   y         out  vertical counter 0..V_TOTAL-1, steps when x wraps
//   hs0       out  stage-0 horizontal sync, active low (combinational)
//   vs0       out  stage-0 vertical sync, active low (combinational)
//   vis0      out  stage-0 visible-area flag (combinational)
module vga_timing
   import vga_pkg::*;
(
   input  logic       clock_25,
   input  logic       reset_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hs0,
   output logic       vs0,
   output logic       vis0
);

   // Frame wrap (799,524 -> 0,0) happens in the same edge as the line wrap,
   // so the frame is exactly H_TOTAL*V_TOTAL clocks.
   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         x <= '0;
         y <= '0;
      end else if (x == 10'(H_TOTAL - 1)) begin
         x <= '0;
         y <= (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
      end else begin
         x <= x + 10'd1;
      end
   end

   always_comb begin
      hs0  = !((x >= 10'(H_SYNC_FIRST)) && (x <= 10'(H_SYNC_LAST)));
      vs0  = !((y >= 10'(V_SYNC_FIRST)) && (y <= 10'(V_SYNC_LAST)));
      vis0 = (x < 10'(H_VIS)) && (y < 10'(V_VIS));
   end

endmodule

// File: rtl/vga_fb.sv
// rtl/vga_fb.sv - 320x240 RRRGGGBB framebuffer scan-out to 640x480 VGA
//
// Optional feature macro: VGA_FB_VBLANK_IRQ_EN (vertical-blank interrupt pulse).
//
// Ports:
//   clock_25    in   pixel clock, 25 MHz, rising edge
//   reset_n     in   asynchronous active-low reset (PLL locked)
//   fb_addr     out  framebuffer byte address, combinational from the counters
//   fb_data     in   framebuffer byte RRRGGGBB, valid one clock after fb_addr
//   VGA_R/G/B   out  4-bit colour, 2 clocks behind the counters
//   VGA_HS/VS   out  sync, active low, 2 clocks behind the counters
//   vblank_irq  out  one-clock pulse at vertical-blank start (0 without the macro)
module vga_fb
   import vga_pkg::*;
(
   input  logic             clock_25,
   input  logic             reset_n,
   output logic [FB_AW-1:0] fb_addr,
   input  logic [7:0]       fb_data,
   output logic [3:0]       VGA_R,
   output logic [3:0]       VGA_G,
   output logic [3:0]       VGA_B,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             vblank_irq
);

   logic [9:0] x;
   logic [9:0] y;
   logic       hs0;
   logic       vs0;
   logic       vis0;
   vga_ctrl_t  st1;

   vga_timing u_timing (
      .clock_25 (clock_25),
      .reset_n  (reset_n),
      .x        (x),
      .y        (y),
      .hs0      (hs0),
      .vs0      (vs0),
      .vis0     (vis0)
   );

   // Address is forced to 0 in blanking so the RAM sees a quiet bus.
   assign fb_addr = vis0 ? fb_index(x, y) : '0;

   // Stage 1: control bits wait here while the RAM fetches the byte.
   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         st1.vis <= 1'b0;
         st1.hs  <= 1'b1;
         st1.vs  <= 1'b1;
      end else begin
         st1.vis <= vis0;
         st1.hs  <= hs0;
         st1.vs  <= vs0;
      end
   end

   // Stage 2: colour expansion replicates the MSBs into the spare low bits.
   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         VGA_R  <= '0;
         VGA_G  <= '0;
         VGA_B  <= '0;
         VGA_HS <= 1'b1;
         VGA_VS <= 1'b1;
      end else begin
         VGA_HS <= st1.hs;
         VGA_VS <= st1.vs;
         if (st1.vis) begin
            VGA_R <= {fb_data[7:5], fb_data[7]};
            VGA_G <= {fb_data[4:2], fb_data[4]};
            VGA_B <= {fb_data[1:0], fb_data[1:0]};
         end else begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
         end
      end
   end

`ifdef VGA_FB_VBLANK_IRQ_EN
   // The pulse rides the same two-stage delay as the video so it lines up
   // with the first blanked line at the output.
   logic irq0;
   logic irq1;

   assign irq0 = (x == 10'd0) && (y == 10'(V_VIS));

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         irq1       <= 1'b0;
         vblank_irq <= 1'b0;
      end else begin
         irq1       <= irq0;
         vblank_irq <= irq1;
      end
   end
`else
   assign vblank_irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb.sv
// tb/tb_vga_fb.sv - self-checking bench for vga_fb
module tb_vga_fb;

   logic        clock_25 = 1'b0;
   logic        reset_n  = 1'b0;
   logic [16:0] fb_addr;
   logic [7:0]  fb_data  = 8'h00;
   logic [3:0]  VGA_R;
   logic [3:0]  VGA_G;
   logic [3:0]  VGA_B;
   logic        VGA_HS;
   logic        VGA_VS;
   logic        vblank_irq;

   int vectors     = 0;
   int miscompares = 0;
   int ram_mode    = 0;
   logic [7:0] mem [76800];

`ifdef VGA_FB_VBLANK_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
      logic        hs;
      logic        vs;
      logic        irq;
      logic [16:0] addr;
   } outs_t;

   typedef struct {
      int         mode;
      int         n;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      logic       hs;
      logic       vs;
   } vec_t;

   vec_t tbl[$];

   vga_fb dut (
      .clock_25   (clock_25),
      .reset_n    (reset_n),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .VGA_R      (VGA_R),
      .VGA_G      (VGA_G),
      .VGA_B      (VGA_B),
      .VGA_HS     (VGA_HS),
      .VGA_VS     (VGA_VS),
      .vblank_irq (vblank_irq)
   );

   always #20 clock_25 = ~clock_25;

   // RAM contents by mode: 0 low address byte, 1 all 0xFF, 2 constant 0xA9, 3 random.
   function automatic logic [7:0] ram_byte(input int a);
      case (ram_mode)
         0:       return a[7:0];
         1:       return 8'hFF;
         2:       return 8'hA9;
         default: return (a >= 0 && a < 76800) ? mem[a] : 8'h00;
      endcase
   endfunction

   // Synchronous RAM: byte appears one clock after the address.
   always @(posedge clock_25) fb_data <= ram_byte(int'(fb_addr));

   // Expected outputs n rising edges after reset release. The screen shows the
   // counter state from two edges earlier; the address reflects the current state.
   function automatic outs_t model(input int n);
      outs_t o;
      int t, x, y, d, c;
      o.r = 4'h0; o.g = 4'h0; o.b = 4'h0;
      o.hs = 1'b1; o.vs = 1'b1; o.irq = 1'b0;
      t = n % 420000;
      x = t % 800;
      y = t / 800;
      o.addr = (x < 640 && y < 480) ? 17'((y / 2) * 320 + x / 2) : 17'd0;
      if (n >= 2) begin
         t = (n - 2) % 420000;
         x = t % 800;
         y = t / 800;
         o.hs  = !(x >= 656 && x < 752);
         o.vs  = !(y >= 490 && y < 492);
         o.irq = IRQ_EN && (t == 480 * 800);
         if (x < 640 && y < 480) begin
            d = int'(ram_byte((y / 2) * 320 + x / 2));
            c = d / 32;         o.r = 4'(c * 2 + c / 4);
            c = (d / 4) % 8;    o.g = 4'(c * 2 + c / 4);
            c = d % 4;          o.b = 4'(c * 5);
         end
      end
      return o;
   endfunction

   task automatic check_cycle(input int n, input string tag);
      outs_t e;
      e = model(n);
      vectors++;
      if (VGA_R !== e.r || VGA_G !== e.g || VGA_B !== e.b || VGA_HS !== e.hs ||
          VGA_VS !== e.vs || vblank_irq !== e.irq || fb_addr !== e.addr) begin
         miscompares++;
         $display("FAIL %s n=%0d got R=%h G=%h B=%h HS=%b VS=%b IRQ=%b ADDR=%0d want R=%h G=%h B=%h HS=%b VS=%b IRQ=%b ADDR=%0d",
                  tag, n, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, vblank_irq, fb_addr,
                  e.r, e.g, e.b, e.hs, e.vs, e.irq, e.addr);
      end
   endtask

   task automatic check_reset_state(input string tag);
      vectors++;
      if (VGA_R !== 4'h0 || VGA_G !== 4'h0 || VGA_B !== 4'h0 || VGA_HS !== 1'b1 ||
          VGA_VS !== 1'b1 || vblank_irq !== 1'b0 || fb_addr !== 17'd0) begin
         miscompares++;
         $display("FAIL %s got R=%h G=%h B=%h HS=%b VS=%b IRQ=%b ADDR=%0d want 0 0 0 1 1 0 0",
                  tag, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, vblank_irq, fb_addr);
      end
   endtask

   task automatic check_count(input string tag, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   // Leaves the bench at a falling edge with reset just released (n = 0).
   task automatic do_reset(input int mode);
      reset_n  = 1'b0;
      ram_mode = mode;
      repeat (2) @(negedge clock_25);
      check_reset_state("reset_state");
      reset_n = 1'b1;
   endtask

   task automatic advance(input int k);
      repeat (k) @(negedge clock_25);
   endtask

   initial begin
      int hs_low, vs_low, irq_cnt, nz;

      for (int i = 0; i < 76800; i++) mem[i] = 8'($urandom);

      // mode, n, R, G, B, HS, VS
      tbl.push_back('{1,    2, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1});  // pixel (0,0)
      tbl.push_back('{1,  641, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1});  // last visible x=639
      tbl.push_back('{1,  642, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1});  // x=640 blank
      tbl.push_back('{1,  657, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1});  // x=655 just before sync
      tbl.push_back('{1,  658, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1});  // first HS low
      tbl.push_back('{1,  753, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1});  // x=751 last sync
      tbl.push_back('{1,  754, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1});  // x=752 back porch
      tbl.push_back('{2,    2, 4'hB, 4'h4, 4'h5, 1'b1, 1'b1});  // 0xA9 expansion
      tbl.push_back('{0,    2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1});  // (0,0) addr 0
      tbl.push_back('{0,  803, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1});  // (1,1) addr 0
      tbl.push_back('{0, 1604, 4'h4, 4'h0, 4'h5, 1'b1, 1'b1});  // (2,2) addr 321 = 0x41
      tbl.push_back('{0,    5, 4'h0, 4'h0, 4'h5, 1'b1, 1'b1});  // (3,0) addr 1
      tbl.push_back('{0,   12, 4'h0, 4'h2, 4'h5, 1'b1, 1'b1});  // (10,0) addr 5

      for (int i = 0; i < tbl.size(); i++) begin
         do_reset(tbl[i].mode);
         advance(tbl[i].n);
         vectors++;
         if (VGA_R !== tbl[i].r || VGA_G !== tbl[i].g || VGA_B !== tbl[i].b ||
             VGA_HS !== tbl[i].hs || VGA_VS !== tbl[i].vs) begin
            miscompares++;
            $display("FAIL table[%0d] n=%0d got R=%h G=%h B=%h HS=%b VS=%b want R=%h G=%h B=%h HS=%b VS=%b",
                     i, tbl[i].n, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
                     tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].hs, tbl[i].vs);
         end
      end

      // One full frame plus the wrap, random RAM contents, every cycle checked.
      do_reset(3);
      hs_low = 0; vs_low = 0; irq_cnt = 0;
      for (int n = 0; n <= 420010; n++) begin
         if (n > 0) advance(1);
         check_cycle(n, "frame");
         if (n >= 2 && n < 420002) begin
            if (!VGA_HS) hs_low++;
            if (!VGA_VS) vs_low++;
            if (vblank_irq) irq_cnt++;
         end
      end
      check_count("hs_low_clocks_per_frame", hs_low, 525 * 96);
      check_count("vs_low_clocks_per_frame", vs_low, 2 * 800);
      check_count("vblank_pulses_per_frame", irq_cnt, IRQ_EN ? 1 : 0);

      // Constant white: 640 lit pixels on each of the first lines.
      do_reset(1);
      advance(2);
      for (int line = 0; line < 3; line++) begin
         nz = 0;
         for (int k = 0; k < 800; k++) begin
            if (k > 0 || line > 0) advance(1);
            if (VGA_R != 4'h0 || VGA_G != 4'h0 || VGA_B != 4'h0) nz++;
         end
         check_count($sformatf("lit_pixels_line%0d", line), nz, 640);
      end

      // Reset mid-line at x=300,y=100: outputs clear without waiting for a clock.
      do_reset(1);
      advance(100 * 800 + 300);
      check_cycle(100 * 800 + 300, "before_midline_reset");
      #5 reset_n = 1'b0;
      #1 check_reset_state("midline_reset_async");
      @(negedge clock_25);
      check_reset_state("midline_reset_held");
      reset_n = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         if (n > 0) advance(1);
         check_cycle(n, "after_midline_reset");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
